fetch_line_buffer: RTL and testbench

Instruction-fetch line buffer sitting directly downstream of the cache-line fetcher (addr_to_data). Holds the most recently fetched 64-byte line with its tag, serves one 32-bit instruction per handshake to the decoder, advances the PC, and triggers a refetch through the fetcher whenever the PC leaves the buffered line or a redirect targets a different line.

---
 rtl/fetch_line_buffer_if.sv | 44 ++++
 rtl/fetch_line_buffer.sv | 157 +++++++++++++++
 tb/tb_fetch_line_buffer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_line_buffer_if.sv
// Fetch line buffer bus: redirect input, fetcher load port and decoder instruction port.
// slave = line buffer side, master = environment side (fetcher, decoder, redirect source).
interface fetch_line_buffer_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int LINE_WIDTH     = 512,
  parameter int INSTR_WIDTH    = 32
);
  logic                      redirect_valid;
  logic [BUS_DATA_WIDTH-1:0] redirect_pc;
  logic                      ld_enable;
  logic [BUS_DATA_WIDTH-1:0] ld_addr;
  logic                      ld_ready;
  logic [LINE_WIDTH-1:0]     ld_data;
  logic                      instr_valid;
  logic                      instr_ready;
  logic [INSTR_WIDTH-1:0]    instr;
  logic [BUS_DATA_WIDTH-1:0] instr_pc;

  modport slave (
    input  redirect_valid,
    input  redirect_pc,
    output ld_enable,
    output ld_addr,
    input  ld_ready,
    input  ld_data,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc
  );

  modport master (
    output redirect_valid,
    output redirect_pc,
    input  ld_enable,
    input  ld_addr,
    output ld_ready,
    output ld_data,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc
  );
endinterface

// File: rtl/fetch_line_buffer.sv
// Instruction-fetch line buffer: holds one 64-byte line, serves 32-bit words to decode.
// Ports: clk, reset (sync, high), bus (slave): redirect, ld_* fetcher port, instr_* port.
module fetch_line_buffer #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int LINE_WIDTH     = 512,
  parameter int INSTR_WIDTH    = 32,
  parameter logic [BUS_DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_line_buffer_if.slave bus
);

  localparam int TW = BUS_DATA_WIDTH - 6;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ARM,
    WAIT,
    SERVE
  } state_e;

  state_e state_q, state_d;

  logic [BUS_DATA_WIDTH-1:0] pc_q, pc_d;
  logic [LINE_WIDTH-1:0]     line_q, line_d;
  logic [TW-1:0]             tag_q, tag_d;
  logic                      line_valid_q, line_valid_d;
  logic                      stale_q, stale_d;
  logic                      ld_enable_q, ld_enable_d;
  logic [BUS_DATA_WIDTH-1:0] ld_addr_q, ld_addr_d;
  logic                      instr_valid_q, instr_valid_d;

  logic [BUS_DATA_WIDTH-1:0] redir_pc;
  logic [TW-1:0]             redir_tag;
  logic [BUS_DATA_WIDTH-1:0] pc_inc;
  logic [3:0]                widx;
  logic                      xfer;

  // word-aligned redirect target; low two bits dropped
  assign redir_pc  = bus.redirect_pc & ~BUS_DATA_WIDTH'(3);
  assign redir_tag = redir_pc[BUS_DATA_WIDTH-1:6];
  assign pc_inc    = pc_q + BUS_DATA_WIDTH'(4);
  assign widx      = pc_q[5:2];
  assign xfer      = instr_valid_q & bus.instr_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    line_d       = line_q;
    tag_d        = tag_q;
    line_valid_d = line_valid_q;
    stale_d      = stale_q;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (bus.redirect_valid) begin
          pc_d = redir_pc;
        end
      end

      REQ: begin
        tag_d        = pc_q[BUS_DATA_WIDTH-1:6];
        stale_d      = 1'b0;
        line_valid_d = 1'b0;
        state_d      = ARM;
        if (bus.redirect_valid) begin
          pc_d    = redir_pc;
          stale_d = redir_tag != pc_q[BUS_DATA_WIDTH-1:6];
        end
      end

      // fetcher may still show the previous line's ready here
      ARM: begin
        state_d = WAIT;
        if (bus.redirect_valid) begin
          pc_d    = redir_pc;
          stale_d = redir_tag != tag_q;
        end
      end

      WAIT: begin
        if (bus.redirect_valid) begin
          pc_d    = redir_pc;
          stale_d = redir_tag != tag_q;
        end
        // a redirect landing with ld_ready also discards the line
        if (bus.ld_ready) begin
          if (stale_d) begin
            state_d = REQ;
          end else begin
            line_d       = bus.ld_data;
            line_valid_d = 1'b1;
            state_d      = SERVE;
          end
        end
      end

      SERVE: begin
        if (bus.redirect_valid) begin
          pc_d = redir_pc;
          if (!(line_valid_q && redir_tag == tag_q)) begin
            state_d = REQ;
          end
        end else if (xfer) begin
          pc_d = pc_inc;
          if (widx == 4'd15) begin
            state_d = REQ;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    ld_enable_d   = state_d == REQ;
    ld_addr_d     = ld_addr_q;
    if (state_d == REQ) begin
      ld_addr_d = {pc_d[BUS_DATA_WIDTH-1:6], 6'b0};
    end
    instr_valid_d = state_d == SERVE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      line_q        <= '0;
      tag_q         <= '0;
      line_valid_q  <= 1'b0;
      stale_q       <= 1'b0;
      ld_enable_q   <= 1'b0;
      ld_addr_q     <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      line_q        <= line_d;
      tag_q         <= tag_d;
      line_valid_q  <= line_valid_d;
      stale_q       <= stale_d;
      ld_enable_q   <= ld_enable_d;
      ld_addr_q     <= ld_addr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign bus.ld_enable   = ld_enable_q;
  assign bus.ld_addr     = ld_addr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_valid_q ?
                           line_q[widx*INSTR_WIDTH +: INSTR_WIDTH] : '0;
  assign bus.instr_pc    = instr_valid_q ? pc_q : '0;

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Bench for fetch_line_buffer: fetcher model, scoreboard monitor, directed scenarios.
// Fetched word i of line at A is 0xA0000000 + (A-0x1000)/4 + i.
module tb_fetch_line_buffer;

  localparam logic [63:0] RST_PC = 64'h1000;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  exp_t        exp_q[$];
  logic [63:0] ld_q[$];

  logic        mon_prev_en;
  exp_t        mon_e;
  logic        f_hold;
  logic        f_busy;
  int          f_cnt;
  int          f_keep;
  logic [63:0] f_addr;

  fetch_line_buffer_if bus ();

  fetch_line_buffer #(
    .BUS_DATA_WIDTH(64),
    .LINE_WIDTH    (512),
    .INSTR_WIDTH   (32),
    .RESET_PC      (RST_PC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_line(input logic [63:0] a);
    logic [511:0] l;
    logic [31:0]  base;
    base = 32'hA000_0000 + 32'((a - 64'h1000) >> 2);
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!bus.instr_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(bus.instr_valid), 64'd1);
  endtask

  // fetcher: ld_ready is a level; optionally keeps old ready through ARM
  initial begin
    bus.ld_ready = 1'b0;
    bus.ld_data  = '0;
    f_busy = 1'b0;
    f_cnt  = 0;
    f_keep = 0;
    f_addr = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        bus.ld_ready = 1'b0;
        f_busy = 1'b0;
      end else if (bus.ld_enable) begin
        f_busy = 1'b1;
        f_cnt  = 3;
        f_addr = bus.ld_addr;
        if (f_hold) begin
          f_keep = 1;
        end else begin
          f_keep = 0;
          bus.ld_ready = 1'b0;
        end
      end else if (f_busy) begin
        if (f_keep > 0) begin
          f_keep--;
        end else if (f_cnt == 0) begin
          bus.ld_ready = 1'b1;
          bus.ld_data  = mk_line(f_addr);
          f_busy = 1'b0;
        end else begin
          bus.ld_ready = 1'b0;
          f_cnt--;
        end
      end
    end
  end

  // monitor: pops expectations on every ld_enable and instruction transfer
  initial begin
    mon_prev_en = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        mon_prev_en = 1'b0;
      end else begin
        if (bus.ld_enable) begin
          chk("ld_enable_twice", 64'(mon_prev_en), 64'd0);
          if (ld_q.size() == 0) chk("unexpected_ld_enable", 64'd1, 64'd0);
          else chk("ld_addr", bus.ld_addr, ld_q.pop_front());
        end
        if (bus.instr_valid && bus.instr_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_instr", bus.instr_pc, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            mon_e = exp_q.pop_front();
            chk("instr", 64'(bus.instr), 64'(mon_e.ins));
            chk("instr_pc", bus.instr_pc, mon_e.pc);
          end
        end
        mon_prev_en = bus.ld_enable;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   good;
    logic bad;
    logic seen;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
    f_hold = 1'b0;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ld_enable", 64'(bus.ld_enable), 64'd0);
    chk("rst_ld_addr", bus.ld_addr, 64'd0);
    chk("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
    chk("rst_instr", 64'(bus.instr), 64'd0);
    chk("rst_instr_pc", bus.instr_pc, 64'd0);

    // line 0x1000 back to back, then 0x1040 with stale ready held through ARM
    ld_q.push_back(64'h1000);
    ld_q.push_back(64'h1040);
    for (int i = 0; i < 16; i++)
      exp_q.push_back('{pc: 64'h1000 + 64'(4*i), ins: 32'hA000_0000 + 32'(i)});
    f_hold = 1'b1;
    bus.instr_ready = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    chk("first_ld_enable", 64'(bus.ld_enable), 64'd1);
    wait_valid("line1000_timeout");
    good = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.instr_valid && bus.instr_ready) good++;
      @(negedge clk);
    end
    chk("back_to_back", 64'(good), 64'd16);

    bus.instr_ready = 1'b0;
    exp_q.push_back('{pc: 64'h1040, ins: 32'hA000_0010});
    wait_valid("line1040_timeout");
    chk("arm_ignores_ready", 64'(bus.instr), 64'hA000_0010);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;

    // redirect to other line 0x1008, then stall 3 cycles
    f_hold = 1'b0;
    ld_q.push_back(64'h1000);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h1008;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    wait_valid("refetch_timeout");
    for (int i = 0; i < 3; i++) begin
      chk("stall_instr", 64'(bus.instr), 64'hA000_0002);
      chk("stall_pc", bus.instr_pc, 64'h1008);
      chk("stall_no_ld", 64'(bus.ld_enable), 64'd0);
      @(negedge clk);
    end
    exp_q.push_back('{pc: 64'h1008, ins: 32'hA000_0002});
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;

    // same-line redirects: 0x1004 then 0x1023 (wins over transfer)
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h1004;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("hit_pc", bus.instr_pc, 64'h1004);
    chk("hit_instr", 64'(bus.instr), 64'hA000_0001);
    exp_q.push_back('{pc: 64'h1004, ins: 32'hA000_0001});
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h1023;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b0;
    chk("redir_valid", 64'(bus.instr_valid), 64'd1);
    chk("redir_pc", bus.instr_pc, 64'h1020);
    chk("redir_instr", 64'(bus.instr), 64'hA000_0008);

    // miss to 0x1080, redirect to 0x2000 during WAIT
    ld_q.push_back(64'h1080);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h1080;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("miss_req", 64'(bus.ld_enable), 64'd1);
    repeat (2) @(negedge clk);
    ld_q.push_back(64'h2000);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h2000;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bad  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bus.instr_valid) bad = 1'b1;
      if (bus.ld_enable) seen = 1'b1;
      else @(negedge clk);
    end
    chk("stale_refetch", 64'(seen), 64'd1);
    chk("stale_no_instr", 64'(bad), 64'd0);
    exp_q.push_back('{pc: 64'h2000, ins: 32'hA000_0400});
    wait_valid("line2000_timeout");
    chk("line2000_pc", bus.instr_pc, 64'h2000);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;

    // reset while waiting on 0x3000
    ld_q.push_back(64'h3000);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h3000;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ld_enable", 64'(bus.ld_enable), 64'd0);
    chk("mid_rst_ld_addr", bus.ld_addr, 64'd0);
    chk("mid_rst_instr_valid", 64'(bus.instr_valid), 64'd0);
    chk("mid_rst_instr", 64'(bus.instr), 64'd0);
    chk("mid_rst_instr_pc", bus.instr_pc, 64'd0);
    ld_q.push_back(RST_PC);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_refetch_en", 64'(bus.ld_enable), 64'd1);
    chk("rst_refetch_addr", bus.ld_addr, RST_PC);
    exp_q.push_back('{pc: RST_PC, ins: 32'hA000_0000});
    wait_valid("post_rst_timeout");
    chk("post_rst_instr", 64'(bus.instr), 64'hA000_0000);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("instr_q_drained", 64'(exp_q.size()), 64'd0);
    chk("ld_q_drained", 64'(ld_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
